// File: rtl/exe_mem_stage.sv
// Execute stage: combinational ALU on the ID/EXE outputs, followed by the
// EXE/MEM pipeline register. Supports stall/flush from hazard logic and
// traps signed overflow on ADD/SUB by killing the instruction's side effects.
module exe_mem_stage #(
   parameter int DATA_W = 32,
   parameter int REG_W  = 5,
   parameter int CNT_W  = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall,
   input  logic              flush,
   input  logic              evalid,
   input  logic              ewreg,
   input  logic              em2reg,
   input  logic              ewmem,
   input  logic [3:0]        ealuc,
   input  logic              ealuimm,
   input  logic [REG_W-1:0]  edestReg,
   input  logic [DATA_W-1:0] eqa,
   input  logic [DATA_W-1:0] eqb,
   input  logic [DATA_W-1:0] eimm32,
   output logic              mvalid,
   output logic              mwreg,
   output logic              mm2reg,
   output logic              mwmem,
   output logic [REG_W-1:0]  mdestReg,
   output logic [DATA_W-1:0] mr,
   output logic [DATA_W-1:0] mqb,
   output logic              movf,
   output logic [CNT_W-1:0]  ovf_count
);

   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SUB = 4'b0110;
   localparam logic [3:0] ALU_SLT = 4'b0111;
   localparam logic [3:0] ALU_NOR = 4'b1100;
   localparam int         MSB     = DATA_W - 1;

   logic [DATA_W-1:0] alu_b;
   logic [DATA_W-1:0] alu_r;
   logic              alu_ovf;
   logic              load;
   logic              trap;
   logic              slt_bit;

   // ALU: operand select, result and signed-overflow detection
   always_comb begin
      alu_b   = ealuimm ? eimm32 : eqb;
      alu_r   = '0;
      alu_ovf = 1'b0;
      slt_bit = ($signed(eqa) < $signed(alu_b));
      case (ealuc)
         ALU_AND: alu_r = eqa & alu_b;
         ALU_OR:  alu_r = eqa | alu_b;
         ALU_ADD: begin
            alu_r   = eqa + alu_b;
            alu_ovf = (eqa[MSB] == alu_b[MSB]) && (alu_r[MSB] != eqa[MSB]);
         end
         ALU_SUB: begin
            alu_r   = eqa - alu_b;
            alu_ovf = (eqa[MSB] != alu_b[MSB]) && (alu_r[MSB] != eqa[MSB]);
         end
         ALU_SLT: alu_r = {{(DATA_W-1){1'b0}}, slt_bit};
         ALU_NOR: alu_r = ~(eqa | alu_b);
         default: alu_r = '0;
      endcase
   end

   // flush beats stall; a stalled cycle simply drops this ALU result
   assign load = !flush && !stall;
   assign trap = evalid && alu_ovf;

   // Control half of EXE/MEM: cleared by flush, suppressed on a trap
   always_ff @(posedge clk) begin
      if (rst) begin
         mvalid <= 1'b0;
         mwreg  <= 1'b0;
         mm2reg <= 1'b0;
         mwmem  <= 1'b0;
         movf   <= 1'b0;
      end else if (flush) begin
         mvalid <= 1'b0;
         mwreg  <= 1'b0;
         mm2reg <= 1'b0;
         mwmem  <= 1'b0;
         movf   <= 1'b0;
      end else if (!stall) begin
         mvalid <= evalid;
         mm2reg <= evalid && em2reg;
         mwreg  <= evalid && ewreg && !alu_ovf;
         mwmem  <= evalid && ewmem && !alu_ovf;
         movf   <= trap;
      end
   end

   // Data half of EXE/MEM: only a real load changes it (flush keeps it)
   always_ff @(posedge clk) begin
      if (rst) begin
         mdestReg <= '0;
         mr       <= '0;
         mqb      <= '0;
      end else if (load) begin
         mdestReg <= edestReg;
         mr       <= alu_r;
         mqb      <= eqb;
      end
   end

   // Saturating count of trapped instructions that actually enter MEM
   always_ff @(posedge clk) begin
      if (rst)
         ovf_count <= '0;
      else if (load && trap && (ovf_count != {CNT_W{1'b1}}))
         ovf_count <= ovf_count + {{(CNT_W-1){1'b0}}, 1'b1};
   end

endmodule

// File: tb/tb_exe_mem_stage.sv
// Scoreboard bench for exe_mem_stage: the driver pushes the expected
// EXE/MEM contents after each edge, a negedge monitor pops and compares.
module tb_exe_mem_stage;

   logic        clk = 1'b0;
   logic        rst, stall, flush, evalid, ewreg, em2reg, ewmem, ealuimm;
   logic [3:0]  ealuc;
   logic [4:0]  edestReg;
   logic [31:0] eqa, eqb, eimm32;
   logic        mvalid, mwreg, mm2reg, mwmem, movf;
   logic [4:0]  mdestReg;
   logic [31:0] mr, mqb;
   logic [7:0]  ovf_count;

   typedef struct {
      logic        mvalid, mwreg, mm2reg, mwmem, movf;
      logic [4:0]  mdest;
      logic [31:0] mr, mqb;
      logic [7:0]  cnt;
   } out_t;

   out_t exp_q[$];
   out_t st;
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   exe_mem_stage #(.DATA_W(32), .REG_W(5), .CNT_W(8)) dut (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush), .evalid(evalid),
      .ewreg(ewreg), .em2reg(em2reg), .ewmem(ewmem), .ealuc(ealuc),
      .ealuimm(ealuimm), .edestReg(edestReg), .eqa(eqa), .eqb(eqb),
      .eimm32(eimm32), .mvalid(mvalid), .mwreg(mwreg), .mm2reg(mm2reg),
      .mwmem(mwmem), .mdestReg(mdestReg), .mr(mr), .mqb(mqb), .movf(movf),
      .ovf_count(ovf_count));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      total++;
      if (act !== expv) begin
         bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, expv, $time);
      end
   endtask

   // monitor: one expected record per clocked cycle
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         out_t e;
         e = exp_q.pop_front();
         chk("mvalid", {31'd0, mvalid}, {31'd0, e.mvalid});
         chk("mwreg",  {31'd0, mwreg},  {31'd0, e.mwreg});
         chk("mm2reg", {31'd0, mm2reg}, {31'd0, e.mm2reg});
         chk("mwmem",  {31'd0, mwmem},  {31'd0, e.mwmem});
         chk("movf",   {31'd0, movf},   {31'd0, e.movf});
         chk("mdest",  {27'd0, mdestReg}, {27'd0, e.mdest});
         chk("mr",     mr,  e.mr);
         chk("mqb",    mqb, e.mqb);
         chk("ovf_count", {24'd0, ovf_count}, {24'd0, e.cnt});
      end
   end

   // apply one cycle of inputs; er/eo are the hand-computed ALU result and
   // overflow flag for this vector; the register behaviour is tracked in st
   task automatic cyc(input logic r, input logic s, input logic f, input logic v,
                      input logic wr, input logic m2r, input logic wm,
                      input logic [3:0] op, input logic imm_sel, input logic [4:0] d,
                      input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm,
                      input logic [31:0] er, input logic eo);
      rst = r; stall = s; flush = f; evalid = v; ewreg = wr; em2reg = m2r;
      ewmem = wm; ealuc = op; ealuimm = imm_sel; edestReg = d;
      eqa = a; eqb = b; eimm32 = imm;
      if (r) begin
         st = '{default: '0};
      end else if (f) begin
         st.mvalid = 0; st.mwreg = 0; st.mm2reg = 0; st.mwmem = 0; st.movf = 0;
      end else if (!s) begin
         st.mdest  = d;
         st.mr     = er;
         st.mqb    = b;
         st.mvalid = v;
         st.mm2reg = v & m2r;
         st.mwreg  = v & wr & ~eo;
         st.mwmem  = v & wm & ~eo;
         st.movf   = v & eo;
         if (v && eo && st.cnt != 8'hFF) st.cnt = st.cnt + 8'd1;
      end
      @(posedge clk);
      exp_q.push_back(st);
      #1;
   endtask

   initial begin
      st = '{default: '0};
      // reset state
      cyc(1,0,0,0, 0,0,0, 4'b0000,0,5'd0, 32'd0,32'd0,32'd0, 32'd0,0);
      cyc(1,0,0,1, 1,1,1, 4'b0010,0,5'd9, 32'd3,32'd4,32'd0, 32'd7,0);
      // ADD 5+7 -> r3
      cyc(0,0,0,1, 1,0,0, 4'b0010,0,5'd3, 32'd5,32'd7,32'd0, 32'd12,0);
      // lw address 0x100 + (-4)
      cyc(0,0,0,1, 1,1,0, 4'b0010,1,5'd4, 32'h100,32'hAA,32'hFFFF_FFFC, 32'h0000_00FC,0);
      // SUB trap with store enable set
      cyc(0,0,0,1, 1,0,1, 4'b0110,0,5'd5, 32'h8000_0000,32'd1,32'd0, 32'h7FFF_FFFF,1);
      // non-overflowing ADD after trap
      cyc(0,0,0,1, 1,0,0, 4'b0010,0,5'd6, 32'd10,32'd20,32'd0, 32'd30,0);
      // logic ops, SLT, undefined code, store
      cyc(0,0,0,1, 1,0,0, 4'b0000,0,5'd7, 32'h0000_F0F0,32'h0000_FF00,32'd0, 32'h0000_F000,0);
      cyc(0,0,0,1, 1,0,0, 4'b0001,0,5'd8, 32'h0000_F0F0,32'h0000_FF00,32'd0, 32'h0000_FFF0,0);
      cyc(0,0,0,1, 1,0,0, 4'b1100,0,5'd9, 32'd0,32'd0,32'd0, 32'hFFFF_FFFF,0);
      cyc(0,0,0,1, 1,0,0, 4'b0111,0,5'd10, 32'hFFFF_FFFF,32'd1,32'd0, 32'd1,0);
      cyc(0,0,0,1, 1,0,0, 4'b0111,0,5'd11, 32'd1,32'hFFFF_FFFF,32'd0, 32'd0,0);
      cyc(0,0,0,1, 1,0,0, 4'b0011,0,5'd12, 32'h7FFF_FFFF,32'd1,32'd0, 32'd0,0);
      cyc(0,0,0,1, 0,0,1, 4'b0010,1,5'd0, 32'h200,32'h55,32'd8, 32'h208,0);
      // invalid slot: data loads, controls cleared
      cyc(0,0,0,0, 1,1,1, 4'b0010,0,5'd13, 32'd1,32'd2,32'd0, 32'd3,0);
      // valid load, then stall twice with changing inputs (incl. a would-be trap)
      cyc(0,0,0,1, 1,0,1, 4'b0010,0,5'd14, 32'd100,32'd1,32'd0, 32'd101,0);
      cyc(0,1,0,1, 0,1,0, 4'b0110,0,5'd15, 32'h8000_0000,32'd1,32'd0, 32'h7FFF_FFFF,1);
      cyc(0,1,0,0, 1,0,0, 4'b0001,0,5'd16, 32'hF,32'hF0,32'd0, 32'hFF,0);
      // stall + flush together: bubble, data held
      cyc(0,1,1,1, 1,1,1, 4'b0010,0,5'd17, 32'h7FFF_FFFF,32'd1,32'd0, 32'h8000_0000,1);
      // flush alone with a trapping instruction: counter unchanged
      cyc(0,0,1,1, 1,0,0, 4'b0010,0,5'd18, 32'h7FFF_FFFF,32'd1,32'd0, 32'h8000_0000,1);
      // rst mid-stream after a valid load, then normal load
      cyc(0,0,0,1, 1,0,0, 4'b0010,0,5'd19, 32'd1,32'd1,32'd0, 32'd2,0);
      cyc(1,0,0,1, 1,0,0, 4'b0010,0,5'd20, 32'd2,32'd2,32'd0, 32'd4,0);
      cyc(0,0,0,1, 1,0,0, 4'b0010,0,5'd21, 32'd3,32'd3,32'd0, 32'd6,0);
      // 260 consecutive trapped ADDs: counter saturates at 255
      for (int i = 0; i < 260; i++)
         cyc(0,0,0,1, 1,0,1, 4'b0010,0,5'd22, 32'h7FFF_FFFF,32'd1,32'd0, 32'h8000_0000,1);
      cyc(0,0,0,1, 1,0,0, 4'b0111,0,5'd23, 32'hFFFF_FFFF,32'd1,32'd0, 32'd1,0);
      // drain the scoreboard with a bounded wait
      for (int k = 0; k < 20 && exp_q.size() > 0; k++) @(posedge clk);
      if (exp_q.size() > 0) begin
         total++; bad++;
         $display("FAIL drain: %0d records left, expected 0", exp_q.size());
      end
      #1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/exe_mem_stage.md
Name: exe_mem_stage

Overview:
- Execute stage of the 5-stage pipelined CPU, directly downstream of the ID/EXE pipeline register.
- Consumes the registered decode outputs (e-prefixed controls, operands, immediate) and performs the ALU operation.
- Registers the result plus memory/writeback controls into the EXE/MEM pipeline register for the memory stage.
- Adds stall/flush support and signed-overflow trapping so later hazard logic can drive it.

Parameters:
DATA_W, 32, operand/result width
REG_W, 5, register-number width
CNT_W, 8, width of saturating overflow counter

Ports:
clk  input  1  pipeline clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
stall  input  1  hold EXE/MEM register contents this cycle
flush  input  1  insert bubble into EXE/MEM this cycle
evalid  input  1  EXE-stage instruction is valid
ewreg  input  1  register-write enable from ID/EXE
em2reg  input  1  writeback selects memory data
ewmem  input  1  data-memory write enable
ealuc  input  4  ALU control code
ealuimm  input  1  1: ALU B operand = eimm32, 0: eqb
edestReg  input  REG_W  destination register number
eqa  input  DATA_W  register operand A
eqb  input  DATA_W  register operand B (also store data)
eimm32  input  DATA_W  sign-extended immediate
mvalid  output  1  MEM-stage instruction valid
mwreg  output  1  registered register-write enable
mm2reg  output  1  registered memory-to-register select
mwmem  output  1  registered memory write enable
mdestReg  output  REG_W  registered destination register
mr  output  DATA_W  registered ALU result (memory address for lw/sw)
mqb  output  DATA_W  registered eqb (store data)
movf  output  1  registered overflow-trap flag for the MEM-stage instruction
ovf_count  output  CNT_W  saturating count of trapped instructions

Behaviour:
- Reset: clk is the only clock. rst is synchronous, active-high. On a rising edge with rst=1, every output = 0, including ovf_count.
- ALU is combinational on e-inputs. B = ealuimm ? eimm32 : eqb.
- ALU ops by ealuc:
  - 0000 AND; 0001 OR; 0010 ADD; 0110 SUB.
  - 0111 SLT: signed compare, result = 1 or 0, zero-extended.
  - 1100 NOR.
  - Any other code: result 0.
- Arithmetic is DATA_W-bit, wrap-around.
- Overflow: evaluated only for ADD/SUB; 0 for all other codes.
  - ADD: A[msb]==B[msb] and R[msb]!=A[msb].
  - SUB: A[msb]!=B[msb] and R[msb]!=A[msb].
- Latency: 1 cycle, e-inputs sampled at edge N appear on m-outputs after edge N.
- Edge priority: rst > flush > stall > load.
- flush=1 (also when stall=1):
  - mvalid, mwreg, mm2reg, mwmem, movf <= 0.
  - mdestReg, mr, mqb hold their previous values.
  - ovf_count unchanged.
- stall=1, flush=0: all outputs hold, including ovf_count. The ALU result is discarded; it is recomputed when the stall releases.
- Load with evalid=0: mvalid, mwreg, mm2reg, mwmem, movf <= 0. Data fields are loaded normally.
- Load with evalid=1:
  - mvalid <= 1; mdestReg <= edestReg; mr <= R; mqb <= eqb; mm2reg <= em2reg.
  - Overflow=0: mwreg <= ewreg; mwmem <= ewmem; movf <= 0.
  - Overflow=1 (trap): mwreg <= 0; mwmem <= 0; movf <= 1; mr still holds the wrapped result; ovf_count increments by 1.
- ovf_count saturates at 2^CNT_W-1 and does not wrap. Only rst clears it.

Test Plan:
- ADD: evalid=1, ealuc=0010, eqa=5, eqb=7, ealuimm=0, ewreg=1, edestReg=3 -> next cycle: mr=12, mwreg=1, mdestReg=3, mvalid=1, movf=0.
- lw address: ealuc=0010, ealuimm=1, eqa=0x100, eimm32=0xFFFFFFFC, em2reg=1, eqb=0xAA -> mr=0xFC, mm2reg=1, mqb=0xAA.
- SUB trap: eqa=0x80000000, eqb=1, ealuc=0110, ewreg=1 -> mr=0x7FFFFFFF, movf=1, mwreg=0, ovf_count=1. Follow with a non-overflow ADD -> movf=0, ovf_count still 1.
- stall: hold stall=1 for 2 cycles while e-inputs change -> m-outputs unchanged. Then assert stall=1 and flush=1 together -> mvalid=mwreg=mwmem=0, mr unchanged.
- rst mid-stream: after a valid load, assert rst for 1 cycle with evalid=1 -> all outputs 0 at that edge. Next edge loads normally.
- Counter saturation: force 260 consecutive trapped ADDs (0x7FFFFFFF+1) -> ovf_count stops at 255. SLT check: eqa=-1, eqb=1, ealuc=0111 -> mr=1.
